// File: rtl/fifo_umbrales.sv
// rtl/fifo_umbrales.sv - data FIFO with programmable low/high occupancy thresholds
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            umbral_bajo,
  input  logic [7:0]            umbral_alto,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic                  rd_acc;
  logic                  wr_acc;
  logic [7:0]            count_ext;

  // Acceptance: a read frees a slot, so a write at full is taken only alongside a read.
  always_comb begin
    rd_acc = rd_enable && !empty;
    wr_acc = wr_enable && (!full || rd_acc);
  end

  // Next-state for pointers, occupancy, read register and the sticky error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (ADDR_WIDTH + 1)'(1);
    end

    // Overflow is a dropped write; underflow is any read attempt on an empty FIFO.
    if ((wr_enable && full && !rd_acc) || (rd_enable && empty)) begin
      error_d = 1'b1;
    end
  end

  // Control registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents survive reset and are only overwritten by accepted writes.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Flags follow the registered count and the live (unlatched) threshold inputs.
  always_comb begin
    count_ext    = {{(8 - ADDR_WIDTH - 1){1'b0}}, count_q};
    empty        = (count_q == '0);
    full         = (count_q == FULL_COUNT);
    almost_empty = (count_ext <= umbral_bajo);
    almost_full  = (count_ext >= umbral_alto);
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign count     = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// tb/tb_fifo_umbrales.sv - self-checking bench for fifo_umbrales
module tb_fifo_umbrales;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] umbral_bajo;
  logic [7:0] umbral_alto;
  logic       wr_enable;
  logic [5:0] data_in;
  logic       rd_enable;
  logic [5:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       error;

  always #5 clk = ~clk;

  fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .umbral_bajo  (umbral_bajo),
    .umbral_alto  (umbral_alto),
    .wr_enable    (wr_enable),
    .data_in      (data_in),
    .rd_enable    (rd_enable),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .error        (error)
  );

  typedef struct {
    bit         rst;
    bit         wr;
    bit         rd;
    logic [5:0] din;
    logic [7:0] bajo;
    logic [7:0] alto;
    int         cnt;
    bit         vld;
    bit         err;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] mdl[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_dout;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit wr, input bit rd, input int din,
                     input int bajo, input int alto, input int cnt, input bit vld, input bit err);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = 6'(din);
    v.bajo = 8'(bajo); v.alto = 8'(alto);
    v.cnt = cnt; v.vld = vld; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    bit rd_acc;
    bit wr_acc;
    reset       = v.rst;
    wr_enable   = v.wr;
    rd_enable   = v.rd;
    data_in     = v.din;
    umbral_bajo = v.bajo;
    umbral_alto = v.alto;
    if (v.rst) begin
      mdl.delete();
      exp_q.delete();
      exp_dout = '0;
    end else begin
      rd_acc = v.rd && (mdl.size() > 0);
      wr_acc = v.wr && ((mdl.size() < 8) || rd_acc);
      if (rd_acc) exp_q.push_back(mdl.pop_front());
      if (wr_acc) mdl.push_back(v.din);
    end
    @(posedge clk);
    #1;
    check("count", int'(count), v.cnt);
    check("empty", int'(empty), int'(v.cnt == 0));
    check("full", int'(full), int'(v.cnt == 8));
    check("almost_empty", int'(almost_empty), int'(v.cnt <= int'(v.bajo)));
    check("almost_full", int'(almost_full), int'(v.cnt >= int'(v.alto)));
    check("valid_out", int'(valid_out), int'(v.vld));
    check("error", int'(error), int'(v.err));
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_sb: valid_out with no expected word, got %0h", data_out);
      end else begin
        exp_dout = exp_q.pop_front();
      end
    end
    check("data_out", int'(data_out), int'(exp_dout));
  endtask

  initial begin
    exp_dout = '0;
    reset = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
    umbral_bajo = 8'd2; umbral_alto = 8'd6;

    // reset state
    add(1, 0, 0, 0, 2, 6, 0, 0, 0);
    // fill with 1..8
    for (int k = 1; k <= 8; k++) add(0, 1, 0, k, 2, 6, k, 0, 0);
    // drain back-to-back
    for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 2, 6, 8 - j, 1, 0);
    add(0, 0, 0, 0, 2, 6, 0, 0, 0);
    // refill, then simultaneous rd+wr at full, then overflow
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 'h10 + k, 2, 6, k, 0, 0);
    add(0, 1, 1, 'h19, 2, 6, 8, 1, 0);
    add(0, 1, 0, 'h1A, 2, 6, 8, 0, 1);
    // threshold boundaries at full: alto beyond depth, bajo equal to depth
    add(0, 0, 0, 0, 8, 9, 8, 0, 1);
    add(0, 0, 0, 0, 7, 8, 8, 0, 1);
    for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 2, 6, 8 - j, 1, 1);
    // underflow at empty
    add(0, 0, 1, 0, 2, 6, 0, 0, 1);
    // clean error, then underflow holding data_out, then wr+rd on empty
    add(1, 0, 0, 0, 2, 6, 0, 0, 0);
    add(0, 1, 0, 'h2A, 2, 6, 1, 0, 0);
    add(0, 0, 1, 0, 2, 6, 0, 1, 0);
    add(0, 0, 0, 0, 2, 6, 0, 0, 0);
    add(0, 0, 1, 0, 2, 6, 0, 0, 1);
    add(0, 1, 1, 'h3F, 2, 6, 1, 0, 1);
    // five words stored, then reset with wr/rd asserted (reset dominates)
    add(1, 0, 0, 0, 2, 6, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 0, 'h20 + k, 2, 6, k, 0, 0);
    add(1, 1, 1, 'h05, 2, 6, 0, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // hand sequence: reset while a popped word is about to be presented
    begin
      vec_t v;
      v.bajo = 8'd2; v.alto = 8'd6; v.din = 6'h31; v.err = 1'b0;
      v.rst = 0; v.wr = 1; v.rd = 0; v.cnt = 1; v.vld = 0; apply(v);
      v.din = 6'h32;                  v.cnt = 2;            apply(v);
      v.wr = 0; v.rd = 1;             v.cnt = 1; v.vld = 1; apply(v);
      v.rst = 1;                      v.cnt = 0; v.vld = 0; apply(v);
      v.rst = 0; v.rd = 0;            v.cnt = 0; v.vld = 0; apply(v);
      v.wr = 1; v.din = 6'h0F;        v.cnt = 1;            apply(v);
      v.wr = 0; v.rd = 1;             v.cnt = 0; v.vld = 1; apply(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
